// File: rtl/exec_sequencer_pkg.sv
// Shared types and constants for the execute sequencer: FSM states, status bit
// positions and the status-update rule applied at writeback.
package exec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } seqState_t;

  localparam int V_BIT = 3;
  localparam int C_BIT = 2;
  localparam int N_BIT = 1;
  localparam int Z_BIT = 0;
  localparam int FUNSEL_LOGIC_BIT = 3;

  // Arithmetic ops take all four flags from the function unit; logic/shift ops
  // keep V and C and derive N/Z from the captured result.
  function automatic logic [3:0] nextStatus(
    input logic       logicOp,
    input logic [3:0] oldStatus,
    input logic [3:0] fuFlags,
    input logic       resultMsb,
    input logic       resultZero
  );
    logic [3:0] ns;
    if (!logicOp) begin
      ns = fuFlags;
    end else begin
      ns        = oldStatus;
      ns[N_BIT] = resultMsb;
      ns[Z_BIT] = resultZero;
    end
    return ns;
  endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// Instruction, function-unit and debug signals between the sequencer (slave)
// and its surroundings (master).
interface exec_sequencer_if #(
  parameter int size = 8
);
  logic            instr_valid;
  logic            instr_ready;
  logic            instr_ldi;
  logic [3:0]      instr_funsel;
  logic [2:0]      instr_dst;
  logic [2:0]      instr_srcA;
  logic [2:0]      instr_srcB;
  logic [size-1:0] instr_imm;
  logic [3:0]      fu_FunSel;
  logic [size-1:0] fu_dataA;
  logic [size-1:0] fu_dataB;
  logic [size-1:0] fu_out;
  logic            fu_V;
  logic            fu_C;
  logic            fu_N;
  logic            fu_Z;
  logic [3:0]      status;
  logic            done;
  logic [2:0]      dbg_addr;
  logic [size-1:0] dbg_data;

  modport slave (
    input  instr_valid, instr_ldi, instr_funsel, instr_dst, instr_srcA, instr_srcB,
           instr_imm, fu_out, fu_V, fu_C, fu_N, fu_Z, dbg_addr,
    output instr_ready, fu_FunSel, fu_dataA, fu_dataB, status, done, dbg_data
  );

  modport master (
    output instr_valid, instr_ldi, instr_funsel, instr_dst, instr_srcA, instr_srcB,
           instr_imm, fu_out, fu_V, fu_C, fu_N, fu_Z, dbg_addr,
    input  instr_ready, fu_FunSel, fu_dataA, fu_dataB, status, done, dbg_data
  );
endinterface

// File: rtl/exec_sequencer_reg_file8.sv
// Register file: one write port, two combinational read ports and a registered
// read-before-write debug port. R0 is never written and always reads zero.
module reg_file8 #(
  parameter int size = 8,
  parameter int REGS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wrEn,
  input  logic [2:0]      wrAddr,
  input  logic [size-1:0] wrData,
  input  logic [2:0]      rdAddrA,
  output logic [size-1:0] rdDataA,
  input  logic [2:0]      rdAddrB,
  output logic [size-1:0] rdDataB,
  input  logic [2:0]      dbgAddr,
  output logic [size-1:0] dbgData
);
  logic [size-1:0] regs [REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REGS; i++) begin
        regs[i] <= '0;
      end
      dbgData <= '0;
    end else begin
      if (wrEn && (wrAddr != 3'd0)) begin
        regs[wrAddr] <= wrData;
      end
      dbgData <= regs[dbgAddr];
    end
  end

  assign rdDataA = (rdAddrA == 3'd0) ? '0 : regs[rdAddrA];
  assign rdDataB = (rdAddrB == 3'd0) ? '0 : regs[rdAddrB];
endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle execute controller in front of the function unit (IDLE/READ/EXEC/WB).
// Optional EXEC_SEQ_STICKY_V_EN adds a v_sticky output latching any arithmetic V=1.
module exec_sequencer
  import exec_pkg::*;
#(
  parameter int size = 8,
  parameter int REGS = 8
) (
  input  logic               clk,
  input  logic               rst,
`ifdef EXEC_SEQ_STICKY_V_EN
  output logic               v_sticky,
`endif
  exec_sequencer_if.slave    bus
);
  seqState_t       stateReg;
  logic            readyReg;
  logic            doneReg;
  logic            ldiReg;
  logic [3:0]      funselReg;
  logic [2:0]      dstReg;
  logic [2:0]      srcAReg;
  logic [2:0]      srcBReg;
  logic [size-1:0] immReg;
  logic [size-1:0] resultReg;
  logic [3:0]      flagsReg;
  logic [3:0]      statusReg;
  logic [3:0]      fuFunSelReg;
  logic [size-1:0] fuDataAReg;
  logic [size-1:0] fuDataBReg;

  logic            wrEn;
  logic [size-1:0] wrData;
  logic [size-1:0] rdDataA;
  logic [size-1:0] rdDataB;

  assign wrEn   = (stateReg == WB);
  assign wrData = ldiReg ? immReg : resultReg;

  reg_file8 #(
    .size (size),
    .REGS (REGS)
  ) uRegFile (
    .clk     (clk),
    .rst     (rst),
    .wrEn    (wrEn),
    .wrAddr  (dstReg),
    .wrData  (wrData),
    .rdAddrA (srcAReg),
    .rdDataA (rdDataA),
    .rdAddrB (srcBReg),
    .rdDataB (rdDataB),
    .dbgAddr (bus.dbg_addr),
    .dbgData (bus.dbg_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg    <= IDLE;
      readyReg    <= 1'b1;
      doneReg     <= 1'b0;
      ldiReg      <= 1'b0;
      funselReg   <= '0;
      dstReg      <= '0;
      srcAReg     <= '0;
      srcBReg     <= '0;
      immReg      <= '0;
      resultReg   <= '0;
      flagsReg    <= '0;
      statusReg   <= '0;
      fuFunSelReg <= '0;
      fuDataAReg  <= '0;
      fuDataBReg  <= '0;
    end else begin
      doneReg <= 1'b0;
      case (stateReg)
        IDLE: begin
          if (bus.instr_valid) begin
            ldiReg    <= bus.instr_ldi;
            funselReg <= bus.instr_funsel;
            dstReg    <= bus.instr_dst;
            srcAReg   <= bus.instr_srcA;
            srcBReg   <= bus.instr_srcB;
            immReg    <= bus.instr_imm;
            readyReg  <= 1'b0;
            stateReg  <= bus.instr_ldi ? WB : READ;
          end
        end
        READ: begin
          fuDataAReg  <= rdDataA;
          fuDataBReg  <= rdDataB;
          fuFunSelReg <= funselReg;
          stateReg    <= EXEC;
        end
        EXEC: begin
          resultReg <= bus.fu_out;
          flagsReg  <= {bus.fu_V, bus.fu_C, bus.fu_N, bus.fu_Z};
          stateReg  <= WB;
        end
        WB: begin
          // The register write itself happens in the register file this same edge.
          if (!ldiReg) begin
            statusReg <= nextStatus(funselReg[FUNSEL_LOGIC_BIT], statusReg, flagsReg,
                                    resultReg[size-1], (resultReg == '0));
          end
          doneReg  <= 1'b1;
          readyReg <= 1'b1;
          stateReg <= IDLE;
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

`ifdef EXEC_SEQ_STICKY_V_EN
  logic vStickyReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      vStickyReg <= 1'b0;
    end else if (stateReg == WB) begin
      if (ldiReg && (dstReg == 3'd0)) begin
        vStickyReg <= 1'b0;
      end else if (!ldiReg && !funselReg[FUNSEL_LOGIC_BIT] && flagsReg[V_BIT]) begin
        vStickyReg <= 1'b1;
      end
    end
  end

  assign v_sticky = vStickyReg;
`else
  // Without the sticky option, V is only visible through the status register.
`endif

  assign bus.instr_ready = readyReg;
  assign bus.done        = doneReg;
  assign bus.status      = statusReg;
  assign bus.fu_FunSel   = fuFunSelReg;
  assign bus.fu_dataA    = fuDataAReg;
  assign bus.fu_dataB    = fuDataBReg;
endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Multi-cycle execute controller directly upstream of the function unit.
- Holds the 8-entry register file and the V/C/N/Z status register.
- Accepts one instruction at a time, reads operands, drives FunSel/dataA/dataB into the function unit, captures its result and flags, and writes them back.

Parameters:
- size, 8, datapath width; matches function unit `size`.
- REGS, 8, register count; address width is clog2(REGS) = 3.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept; high only in IDLE.
- instr_ldi  in  1  1 = load immediate; 0 = function-unit op.
- instr_funsel  in  4  FunSel for a function-unit op.
- instr_dst  in  3  destination register.
- instr_srcA  in  3  operand A register.
- instr_srcB  in  3  operand B register.
- instr_imm  in  size  immediate for LDI.
- fu_FunSel  out  4  to function unit.
- fu_dataA  out  size  to function unit.
- fu_dataB  out  size  to function unit.
- fu_out  in  size  FuntionOut from function unit.
- fu_V, fu_C, fu_N, fu_Z  in  1 each  flags from function unit.
- status  out  4  {V,C,N,Z} register.
- done  out  1  one-cycle pulse on writeback.
- dbg_addr  in  3  debug read address.
- dbg_data  out  size  registered debug read data.

Behaviour:
- Reset: state=IDLE, all registers 0, status=0, fu_FunSel/fu_dataA/fu_dataB=0, done=0, dbg_data=0. Reset mid-operation aborts with no writeback.
- States and transitions:
  - IDLE: instr_ready=1. On instr_valid, latch the instruction. LDI goes to WB; otherwise go to READ.
  - READ: register fu_dataA=R[srcA], fu_dataB=R[srcB], fu_FunSel=funsel. Go to EXEC.
  - EXEC: fu_* inputs held stable. Capture fu_out and flags into result/flag registers. Go to WB.
  - WB: R[dst] <= result (or imm for LDI); update status; done=1. Go to IDLE.
- Latency: accept at edge 0; FU op completes done at cycle 3, LDI at cycle 1. Next accept is the cycle after done.
- fu_* outputs hold their last values outside READ/EXEC.
- R0 reads as 0; writes to R0 are discarded. Flags still update.
- Flag rule:
  - FunSel[3]=0 (arithmetic): status={fu_V,fu_C,fu_N,fu_Z}.
  - FunSel[3]=1 (logic/shift): V and C unchanged, N=result[size-1], Z=(result==0).
  - LDI: status unchanged.
- srcA==srcB is legal. dst equal to a source is legal; the source was read in READ.
- Debug port: dbg_data <= R[dbg_addr] each cycle. A WB write to the same address in the same cycle returns the old value (read-before-write).
- instr_valid while instr_ready=0 is ignored; the instruction is not latched.

Optional Feature:
- Macro EXEC_SEQ_STICKY_V_EN.
  - Defined: adds output `v_sticky`, set whenever an arithmetic WB writes V=1. Cleared only by rst or by an LDI to R0.
  - Undefined: port absent, no extra logic.

Decomposition:
- Shared package exec_pkg:
  - State enum {IDLE, READ, EXEC, WB}.
  - Status bit indices V=3, C=2, N=1, Z=0.
  - FUNSEL_LOGIC_BIT=3.
- One natural sub-module: reg_file8 (8 x size, one write port, two combinational read ports plus the registered debug port, R0 hard-wired to zero).

Test Plan:
1. Reset then dbg_addr sweep 0..7 -> dbg_data=0x00 everywhere; status=0000; instr_ready=1.
2. LDI R1=0x7F, LDI R2=0x01 -> done one cycle after each accept; dbg R1=0x7F, R2=0x01; status unchanged.
3. Op funsel=4'b0001, srcA=1, srcB=2, dst=3; stub returns fu_out=0x80, V=1,C=0,N=1,Z=0.
   - In EXEC: fu_dataA=0x7F, fu_dataB=0x01, fu_FunSel=0001.
   - done at cycle 3; R3=0x80; status=1010.
4. After test 3, op funsel=4'b1000, dst=4; stub returns fu_out=0x00, all flags 0 -> R4=0x00; status=1001 (V kept, C kept 0, N=0, Z=1).
5. Op with dst=0; stub fu_out=0x55 -> R0 still reads 0x00; status updated; done pulses.
6. Assert rst in EXEC with dst=5 -> R5 unchanged (0x00), state IDLE next cycle, no done. instr_valid held high during READ -> second instruction not taken until instr_ready.
